// File: rtl/pwm_fade.sv
// pwm_fade: trapezoidal "breathing" duty ramp feeding a downstream pwm block.
// Ports: clk/rst (async active-low), i_enable, i_max_duty (plateau), i_step (0 acts as 1)
//        -> o_duty_cycle (to pwm), o_tick (period-boundary pulse), o_phase (IDLE..HOLD_LOW).
// Latency: duty/phase/tick update on the period-wrap edge; disable forces IDLE on the next edge.
module pwm_fade #(
  parameter int CLK_FREQ     = 100000000,
  parameter int PWM_FREQ     = 20000,
  parameter int WL           = $clog2(CLK_FREQ / PWM_FREQ),
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enable,
  input  logic [WL-1:0] i_max_duty,
  input  logic [WL-1:0] i_step,
  output logic [WL-1:0] o_duty_cycle,
  output logic          o_tick,
  output logic [2:0]    o_phase
);

  localparam int PWM_MAX_CNT = CLK_FREQ / PWM_FREQ;
  localparam int CW          = $clog2(PWM_MAX_CNT + 1);
  localparam int EVT_MAX     = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
  localparam int EW          = $clog2(EVT_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(PWM_MAX_CNT);
  localparam logic [EW-1:0] STEP_LAST = EW'(STEP_PERIODS);
  localparam logic [EW-1:0] HOLD_LAST = EW'(HOLD_PERIODS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } phase_e;

  logic [CW-1:0] cnt_q;
  logic          tick_q;
  phase_e        state_q, state_d;
  logic [WL-1:0] duty_q, duty_d;
  logic [EW-1:0] evt_q, evt_d;

  logic          wrap;
  logic [EW-1:0] evt_inc;
  logic          step_due;
  logic          hold_due;
  logic [WL-1:0] step_eff;
  logic [WL:0]   up_sum;
  logic          up_reached;
  logic [WL-1:0] up_val;
  logic [WL-1:0] dn_val;

  // Period counter matches the pwm period; the wrap edge is the only edge
  // on which the ramp advances, so duty changes land on pwm period starts.
  assign wrap = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= wrap ? '0 : cnt_q + CW'(1);
      tick_q <= wrap;
    end
  end

  // Ramp arithmetic. The up-sum is one bit wider so a large step saturates
  // at the plateau instead of wrapping back to a small duty.
  assign evt_inc    = evt_q + EW'(1);
  assign step_due   = (evt_inc == STEP_LAST);
  assign hold_due   = (evt_inc == HOLD_LAST);
  assign step_eff   = (i_step == '0) ? WL'(1) : i_step;
  assign up_sum     = {1'b0, duty_q} + {1'b0, step_eff};
  assign up_reached = (up_sum >= {1'b0, i_max_duty});
  assign up_val     = up_reached ? i_max_duty : up_sum[WL-1:0];
  assign dn_val     = (duty_q > step_eff) ? (duty_q - step_eff) : '0;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      evt_q   <= evt_d;
    end
  end

  // Next-state logic. The event counter counts wraps within a state and is
  // also restarted after each ramp step so it paces every STEP_PERIODS-th wrap.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    evt_d   = evt_q;
    if (!i_enable) begin
      // Disable is immediate, not wrap-aligned.
      state_d = IDLE;
      duty_d  = '0;
      evt_d   = '0;
    end else if (wrap) begin
      case (state_q)
        IDLE: begin
          state_d = RAMP_UP;
          duty_d  = '0;
          evt_d   = '0;
        end
        RAMP_UP: begin
          if (step_due) begin
            evt_d  = '0;
            duty_d = up_val;
            if (up_reached) state_d = HOLD_HIGH;
          end else begin
            evt_d = evt_inc;
          end
        end
        HOLD_HIGH: begin
          if (hold_due) begin
            state_d = RAMP_DOWN;
            evt_d   = '0;
          end else begin
            evt_d = evt_inc;
          end
        end
        RAMP_DOWN: begin
          if (step_due) begin
            evt_d  = '0;
            duty_d = dn_val;
            if (dn_val == '0) state_d = HOLD_LOW;
          end else begin
            evt_d = evt_inc;
          end
        end
        HOLD_LOW: begin
          duty_d = '0;
          if (hold_due) begin
            state_d = RAMP_UP;
            evt_d   = '0;
          end else begin
            evt_d = evt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
          evt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are straight from registers: glitch-free toward pwm.
  always_comb begin
    o_phase      = state_q;
    o_duty_cycle = duty_q;
    o_tick       = tick_q;
  end

endmodule

// File: tb/tb_pwm_fade.sv
module tb_pwm_fade;

  localparam int WL   = 4;
  localparam int PER  = 11;
  localparam int STEP = 2;
  localparam int HOLD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [WL-1:0] max_d = '0;
  logic [WL-1:0] step_v = '0;
  logic [WL-1:0] o_duty_cycle;
  logic          o_tick;
  logic [2:0]    o_phase;

  int total = 0;
  int bad   = 0;

  // Reference model state, tracked per clock edge from the documented rules.
  int m_cyc, m_duty, m_phase, m_n;
  bit m_tick;

  pwm_fade #(
    .CLK_FREQ(1000), .PWM_FREQ(100), .WL(WL),
    .STEP_PERIODS(STEP), .HOLD_PERIODS(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(en), .i_max_duty(max_d), .i_step(step_v),
    .o_duty_cycle(o_duty_cycle), .o_tick(o_tick), .o_phase(o_phase)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int s;
    int mx;
    s  = (step_v == 0) ? 1 : int'(step_v);
    mx = int'(max_d);
    m_cyc++;
    m_tick = (m_cyc % PER == 0);
    if (!en) begin
      m_phase = 0; m_duty = 0; m_n = 0;
    end else if (m_tick) begin
      case (m_phase)
        0: begin m_phase = 1; m_duty = 0; m_n = 0; end
        1: begin
          m_n++;
          if (m_n == STEP) begin
            m_n = 0;
            m_duty = (m_duty + s > mx) ? mx : m_duty + s;
            if (m_duty >= mx) m_phase = 2;
          end
        end
        2: begin
          m_n++;
          if (m_n == HOLD) begin m_phase = 3; m_n = 0; end
        end
        3: begin
          m_n++;
          if (m_n == STEP) begin
            m_n = 0;
            m_duty = (m_duty > s) ? m_duty - s : 0;
            if (m_duty == 0) m_phase = 4;
          end
        end
        default: begin
          m_duty = 0;
          m_n++;
          if (m_n == HOLD) begin m_phase = 1; m_n = 0; end
        end
      endcase
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_cyc = 0; m_duty = 0; m_phase = 0; m_n = 0; m_tick = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; max_d = 4'd8; step_v = 4'd3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({o_tick, o_phase, o_duty_cycle} !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got t=%0d p=%0d d=%0d exp all 0", o_tick, o_phase, o_duty_cycle);
    end
    @(negedge clk);
    rst = 1'b1;
    m_cyc = 0; m_duty = 0; m_phase = 0; m_n = 0; m_tick = 1'b0;
    #1;
    total++;
    if ({o_tick, o_phase, o_duty_cycle} !== 8'h00) begin
      bad++;
      $display("FAIL cycle0 got t=%0d p=%0d d=%0d exp all 0", o_tick, o_phase, o_duty_cycle);
    end
  endtask

  task automatic test_tick_cadence();
    bit exp_t;
    en = 1'b0;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      clk_edge();
      exp_t = (c == 11 || c == 22 || c == 33);
      total++;
      if (o_tick !== exp_t || o_phase !== 3'd0 || o_duty_cycle !== 4'd0) begin
        bad++;
        $display("FAIL tick_cadence c=%0d got t=%0d p=%0d d=%0d exp t=%0d p=0 d=0",
                 c, o_tick, o_phase, o_duty_cycle, exp_t);
      end
    end
  endtask

  task automatic test_full_cycle();
    int tk[10] = '{1, 3, 5, 7, 10, 12, 14, 16, 19, 21};
    int td[10] = '{0, 3, 6, 8, 8, 5, 2, 0, 0, 3};
    int tp[10] = '{1, 1, 1, 2, 3, 3, 3, 4, 1, 1};
    en = 1'b1; max_d = 4'd8; step_v = 4'd3;
    do_reset();
    for (int c = 1; c <= 21 * PER + 2; c++) begin
      clk_edge();
      total++;
      if ({o_tick, o_phase, o_duty_cycle} !== {m_tick, 3'(m_phase), 4'(m_duty)}) begin
        bad++;
        $display("FAIL full_cycle_model c=%0d got t=%0d p=%0d d=%0d exp t=%0d p=%0d d=%0d",
                 c, o_tick, o_phase, o_duty_cycle, m_tick, m_phase, m_duty);
      end
      for (int i = 0; i < 10; i++) begin
        if (tk[i] * PER == c) begin
          total++;
          if (o_duty_cycle !== 4'(td[i]) || o_phase !== 3'(tp[i]) || o_tick !== 1'b1) begin
            bad++;
            $display("FAIL full_cycle_t%0d got d=%0d p=%0d t=%0d exp d=%0d p=%0d t=1",
                     tk[i], o_duty_cycle, o_phase, o_tick, td[i], tp[i]);
          end
        end
      end
    end
  endtask

  task automatic test_saturation();
    int seq[$];
    logic [WL-1:0] prev;
    bit done;
    en = 1'b1; max_d = 4'd15; step_v = 4'd7;
    do_reset();
    prev = '0;
    done = 1'b0;
    for (int c = 1; c <= 10 * PER && !done; c++) begin
      clk_edge();
      total++;
      if ({o_tick, o_phase, o_duty_cycle} !== {m_tick, 3'(m_phase), 4'(m_duty)}) begin
        bad++;
        $display("FAIL saturation_model c=%0d got p=%0d d=%0d exp p=%0d d=%0d",
                 c, o_phase, o_duty_cycle, m_phase, m_duty);
      end
      if (o_duty_cycle !== prev) begin
        seq.push_back(int'(o_duty_cycle));
        prev = o_duty_cycle;
      end
      if (o_phase == 3'd2) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL saturation_timeout got phase=%0d exp phase=2 within budget", o_phase);
    end
    total++;
    if (seq.size() != 3 || seq[0] != 7 || seq[1] != 14 || seq[2] != 15) begin
      bad++;
      $display("FAIL saturation_seq got n=%0d last=%0d exp 7,14,15", seq.size(),
               (seq.size() > 0) ? seq[seq.size()-1] : -1);
    end
  endtask

  task automatic test_step_zero();
    bit hit;
    en = 1'b1; max_d = 4'd8; step_v = 4'd0;
    do_reset();
    hit = 1'b0;
    for (int c = 1; c <= 12 * PER && !hit; c++) begin
      clk_edge();
      total++;
      if ({o_tick, o_phase, o_duty_cycle} !== {m_tick, 3'(m_phase), 4'(m_duty)}) begin
        bad++;
        $display("FAIL step_zero_model c=%0d got p=%0d d=%0d exp p=%0d d=%0d",
                 c, o_phase, o_duty_cycle, m_phase, m_duty);
      end
      if (o_duty_cycle == 4'd4) hit = 1'b1;
    end
    total++;
    if (!hit || m_cyc != 9 * PER) begin
      bad++;
      $display("FAIL step_zero_reach4 got cycle=%0d exp cycle=%0d", m_cyc, 9 * PER);
    end
    max_d = 4'd2;
    hit = 1'b0;
    for (int c = 0; c < 4 * PER && !hit; c++) begin
      clk_edge();
      if (o_duty_cycle !== 4'd4) hit = 1'b1;
    end
    total++;
    if (!hit || o_duty_cycle !== 4'd2 || o_phase !== 3'd2) begin
      bad++;
      $display("FAIL step_zero_clamp got d=%0d p=%0d exp d=2 p=2", o_duty_cycle, o_phase);
    end
  endtask

  task automatic test_disable();
    en = 1'b1; max_d = 4'd8; step_v = 4'd3;
    do_reset();
    while (m_cyc < 60) clk_edge();
    total++;
    if (o_phase !== 3'd1 || o_duty_cycle !== 4'd6) begin
      bad++;
      $display("FAIL disable_pre got p=%0d d=%0d exp p=1 d=6", o_phase, o_duty_cycle);
    end
    en = 1'b0;
    clk_edge();
    total++;
    if (o_phase !== 3'd0 || o_duty_cycle !== 4'd0) begin
      bad++;
      $display("FAIL disable_c61 got p=%0d d=%0d exp p=0 d=0", o_phase, o_duty_cycle);
    end
    clk_edge();
    en = 1'b1;
    while (m_cyc < 66) begin
      clk_edge();
      total++;
      if ({o_tick, o_phase, o_duty_cycle} !== {m_tick, 3'(m_phase), 4'(m_duty)}) begin
        bad++;
        $display("FAIL disable_model c=%0d got t=%0d p=%0d d=%0d exp t=%0d p=%0d d=%0d",
                 m_cyc, o_tick, o_phase, o_duty_cycle, m_tick, m_phase, m_duty);
      end
    end
    total++;
    if (o_phase !== 3'd1 || o_tick !== 1'b1) begin
      bad++;
      $display("FAIL reenable_t6 got p=%0d t=%0d exp p=1 t=1", o_phase, o_tick);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; max_d = 4'd8; step_v = 4'd3;
    do_reset();
    while (m_cyc < 80) clk_edge();
    total++;
    if (o_phase !== 3'd2 || o_duty_cycle !== 4'd8) begin
      bad++;
      $display("FAIL async_pre got p=%0d d=%0d exp p=2 d=8", o_phase, o_duty_cycle);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({o_tick, o_phase, o_duty_cycle} !== 8'h00) begin
      bad++;
      $display("FAIL async_clear got t=%0d p=%0d d=%0d exp all 0", o_tick, o_phase, o_duty_cycle);
    end
    @(negedge clk);
    rst = 1'b1;
    m_cyc = 0; m_duty = 0; m_phase = 0; m_n = 0; m_tick = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      clk_edge();
      total++;
      if (o_tick !== (c == 11) ||
          {o_tick, o_phase, o_duty_cycle} !== {m_tick, 3'(m_phase), 4'(m_duty)}) begin
        bad++;
        $display("FAIL async_restart c=%0d got t=%0d p=%0d d=%0d exp t=%0d p=%0d d=%0d",
                 c, o_tick, o_phase, o_duty_cycle, (c == 11), m_phase, m_duty);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      en = 1'b1;
      max_d = 4'($urandom_range(0, 15));
      step_v = 4'($urandom_range(0, 15));
      do_reset();
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 149) == 0) max_d = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 199) == 0) step_v = 4'($urandom_range(0, 15));
        if (en && $urandom_range(0, 299) == 0) en = 1'b0;
        else if (!en && $urandom_range(0, 4) == 0) en = 1'b1;
        clk_edge();
        total++;
        if ({o_tick, o_phase, o_duty_cycle} !== {m_tick, 3'(m_phase), 4'(m_duty)}) begin
          bad++;
          $display("FAIL random it=%0d c=%0d got t=%0d p=%0d d=%0d exp t=%0d p=%0d d=%0d",
                   it, m_cyc, o_tick, o_phase, o_duty_cycle, m_tick, m_phase, m_duty);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick_cadence();
    test_full_cycle();
    test_saturation();
    test_step_zero();
    test_disable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
